// File: rtl/mmu_pkg.sv
// mmu_pkg: shared encodings and default widths for the l1mmu refill/writeback port.
//   ARB_* : arbiter FSM states, OWNER_* : which cache holds the port.
package mmu_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D, ARB_RELEASE} arb_state_t;
  typedef enum logic {OWNER_I, OWNER_D} owner_t;
endpackage

// File: rtl/l1mmu_arbiter.sv
// l1mmu_arbiter: round-robin share of the single l1mmu port between L1 I-cache and D-cache.
//   ic_read/ic_addr -> ic_done/ic_read_data                 : I-cache line reads
//   dc_read/dc_write/dc_addr/dc_write_data -> dc_done/...   : D-cache reads and writebacks
//   mmu_read/mmu_write/mmu_addr/mmu_write_data, mmu_done/mmu_read_data : l1mmu side
//   arb_busy : transaction outstanding, arb_timeout : sticky watchdog flag
module l1mmu_arbiter
  import mmu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_read_data,
  output logic              mmu_read,
  output logic              mmu_write,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              arb_busy,
  output logic              arb_timeout
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  arb_state_t        state;
  owner_t            last_owner;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_data;
  logic              lat_write;
  logic [CW-1:0]     wd_cnt;
  logic              req_d, pick_d, granted;
  assign req_d   = dc_read | dc_write;
  // D wins when it is alone, or on a tie when I held the port last
  assign pick_d  = req_d & (~ic_read | last_owner == OWNER_I);
  assign granted = state == ARB_GRANT_I || state == ARB_GRANT_D;
  // l1mmu sees only latched values, so its inputs cannot move mid-transaction
  assign mmu_read       = granted & ~lat_write;
  assign mmu_write      = granted & lat_write;
  assign mmu_addr       = lat_addr;
  assign mmu_write_data = lat_data;
  assign ic_done        = state == ARB_GRANT_I && mmu_done;
  assign dc_done        = state == ARB_GRANT_D && mmu_done;
  assign ic_read_data   = mmu_read_data;
  assign dc_read_data   = mmu_read_data;
  assign arb_busy       = granted;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state       <= ARB_IDLE;
      last_owner  <= OWNER_D;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_write   <= 1'b0;
      wd_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE:
          if (ic_read | req_d) begin
            state      <= pick_d ? ARB_GRANT_D : ARB_GRANT_I;
            last_owner <= pick_d ? OWNER_D : OWNER_I;
            lat_addr   <= pick_d ? dc_addr : ic_addr;
            lat_data   <= pick_d ? dc_write_data : '0;
            lat_write  <= pick_d & dc_write;
            wd_cnt     <= '0;
          end
        ARB_GRANT_I, ARB_GRANT_D: begin
          if (mmu_done) state <= ARB_RELEASE;
          // saturating count; the flag rises on the edge the count reaches TIMEOUT
          if (wd_cnt != CW'(TIMEOUT)) wd_cnt <= wd_cnt + CW'(1);
          if (TIMEOUT != 0 && wd_cnt == CW'(TIMEOUT - 1)) arb_timeout <= 1'b1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
endmodule

// File: tb/tb_l1mmu_arbiter.sv
// tb_l1mmu_arbiter: scoreboard and table-driven checks of l1mmu_arbiter with a small l1mmu model.
module tb_l1mmu_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 16;
  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ic_read, dc_read, dc_write, mmu_done;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_write_data, mmu_read_data;
  logic          ic_done, dc_done, mmu_read, mmu_write, arb_busy, arb_timeout;
  logic [LW-1:0] ic_read_data, dc_read_data, mmu_write_data;
  logic [AW-1:0] mmu_addr;
  l1mmu_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_done(ic_done), .ic_read_data(ic_read_data),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_write_data(dc_write_data),
    .dc_done(dc_done), .dc_read_data(dc_read_data),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_write_data(mmu_write_data), .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
    .arb_busy(arb_busy), .arb_timeout(arb_timeout)
  );
  always #5 sys_clk = ~sys_clk;
  typedef struct {bit own_d; bit wr; logic [AW-1:0] addr; logic [LW-1:0] wdata;} txn_t;
  typedef struct {bit ic; bit dr; bit dw; bit d_first;} vec_t;
  txn_t          q[$];
  txn_t          cur;
  int            n_chk = 0, n_fail = 0;
  int            lat = 5, cyc = 0;
  bit            hang = 0, late_done = 0, active = 0, rel_chk = 0;
  logic [LW-1:0] rd_next;
  function automatic logic [LW-1:0] rnd();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32+:32] = $urandom;
    return v;
  endfunction
  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // l1mmu model + requesters: accepts a transaction, checks it against the scoreboard,
  // answers after lat cycles and drops the owning cache's level on its done pulse
  initial begin : agent
    mmu_done = 1'b0;
    mmu_read_data = '0;
    forever begin
      @(negedge sys_clk);
      mmu_done = 1'b0;
      #1;
      if (rel_chk) begin
        chk("release_gap", {arb_busy, mmu_read, mmu_write}, '0);
        rel_chk = 0;
      end
      if (mmu_read | mmu_write) begin
        if (!active) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_txn: got addr %0h write %0b, expected no transaction", mmu_addr, mmu_write);
            cur = '{own_d: 1'b0, wr: mmu_write, addr: mmu_addr, wdata: mmu_write_data};
          end else cur = q.pop_front();
          active = 1;
          cyc = 0;
        end
        chk("txn_type", {mmu_read, mmu_write}, {!cur.wr, cur.wr});
        chk("txn_addr", mmu_addr, cur.addr);
        if (cur.wr) chk("txn_wdata", mmu_write_data, cur.wdata);
        chk("no_early_done", {ic_done, dc_done}, '0);
        chk("busy_in_grant", arb_busy, 1'b1);
        cyc++;
        if ((!hang && cyc == lat) || late_done) begin
          mmu_read_data = rd_next;
          rd_next = rnd();
          mmu_done = 1'b1;
          late_done = 0;
          #1;
          chk("ic_done", ic_done, !cur.own_d);
          chk("dc_done", dc_done, cur.own_d);
          chk("ic_read_data", ic_read_data, mmu_read_data);
          chk("dc_read_data", dc_read_data, mmu_read_data);
          if (cur.own_d) begin
            dc_read = 1'b0;
            dc_write = 1'b0;
          end else ic_read = 1'b0;
          active = 0;
          rel_chk = 1;
        end
      end
    end
  end
  task automatic quiesce();
    for (int k = 0; k < 200; k++) begin
      @(negedge sys_clk);
      #3;
      if (q.size() == 0 && !active && !rel_chk && !arb_busy && !ic_read && !dc_read && !dc_write) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL quiesce_timeout: got %0d pending, expected 0 within 200 cycles", q.size());
    q.delete();
    ic_read = 1'b0;
    dc_read = 1'b0;
    dc_write = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    #2;
    rst_n = 1'b1;
  endtask
  initial begin : main
    vec_t          tab[6];
    txn_t          ti, td;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd;
    tab = '{'{1, 0, 0, 0}, '{1, 0, 1, 1}, '{0, 1, 0, 1}, '{1, 1, 0, 0}, '{0, 0, 1, 1}, '{1, 0, 1, 0}};
    ic_read = 1'b1;
    ic_addr = 32'h0040_0020;
    dc_read = 1'b0;
    dc_write = 1'b0;
    dc_addr = '0;
    dc_write_data = '0;
    rd_next = {32{8'hA5}};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    #2;
    chk("rst_mmu_rw", {mmu_read, mmu_write}, '0);
    chk("rst_done", {ic_done, dc_done}, '0);
    chk("rst_busy_timeout", {arb_busy, arb_timeout}, '0);
    chk("rst_mmu_addr", mmu_addr, '0);
    chk("rst_mmu_wdata", mmu_write_data, '0);
    q.push_back('{own_d: 1'b0, wr: 1'b0, addr: 32'h0040_0020, wdata: '0});
    rst_n = 1'b1;
    @(negedge sys_clk);
    #2;
    chk("first_grant_read", {mmu_read, mmu_write}, 2'b10);
    chk("first_grant_addr", mmu_addr, 32'h0040_0020);
    quiesce();
    chk("single_ic_data", ic_read_data, {32{8'hA5}});
    do_reset();
    @(negedge sys_clk);
    #2;
    wd = rnd();
    ia = $urandom;
    q.push_back('{own_d: 1'b0, wr: 1'b0, addr: ia, wdata: '0});
    q.push_back('{own_d: 1'b1, wr: 1'b1, addr: 32'h1001_0000, wdata: wd});
    ic_read = 1'b1;
    ic_addr = ia;
    dc_write = 1'b1;
    dc_addr = 32'h1001_0000;
    dc_write_data = wd;
    quiesce();
    for (int i = 0; i < 6; i++) begin
      ia = $urandom;
      da = $urandom;
      wd = rnd();
      ti = '{own_d: 1'b0, wr: 1'b0, addr: ia, wdata: '0};
      td = '{own_d: 1'b1, wr: tab[i].dw, addr: da, wdata: wd};
      if (tab[i].d_first) begin
        q.push_back(td);
        if (tab[i].ic) q.push_back(ti);
      end else begin
        q.push_back(ti);
        if (tab[i].dr | tab[i].dw) q.push_back(td);
      end
      ic_addr = ia;
      dc_addr = da;
      dc_write_data = wd;
      ic_read = tab[i].ic;
      dc_read = tab[i].dr;
      dc_write = tab[i].dw;
      quiesce();
    end
    lat = 8;
    wd = rnd();
    q.push_back('{own_d: 1'b1, wr: 1'b1, addr: 32'h1001_0040, wdata: wd});
    dc_addr = 32'h1001_0040;
    dc_write_data = wd;
    dc_write = 1'b1;
    repeat (3) @(negedge sys_clk);
    #2;
    dc_addr = 32'hDEAD_BEE0;
    dc_write_data = rnd();
    quiesce();
    lat = 6;
    ia = $urandom;
    q.push_back('{own_d: 1'b0, wr: 1'b0, addr: ia, wdata: '0});
    ic_addr = ia;
    ic_read = 1'b1;
    repeat (3) @(negedge sys_clk);
    #2;
    ic_read = 1'b0;
    @(negedge sys_clk);
    #2;
    chk("drop_hold_read", mmu_read, 1'b1);
    quiesce();
    for (int j = 0; j < 3; j++) begin
      @(negedge sys_clk);
      #2;
      chk("drop_back_idle", {arb_busy, mmu_read, mmu_write}, '0);
    end
    lat = 5;
    @(negedge sys_clk);
    #2;
    mmu_done = 1'b1;
    #1;
    chk("stray_done", {ic_done, dc_done}, '0);
    @(negedge sys_clk);
    #2;
    chk("stray_done_idle", arb_busy, 1'b0);
    chk("no_timeout_yet", arb_timeout, 1'b0);
    hang = 1;
    ia = $urandom;
    q.push_back('{own_d: 1'b0, wr: 1'b0, addr: ia, wdata: '0});
    ic_addr = ia;
    ic_read = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge sys_clk);
      #2;
      if (j == 16) chk("wd_before_limit", arb_timeout, 1'b0);
      if (j >= 17) chk("wd_set", arb_timeout, 1'b1);
      if (j == 20) chk("wd_still_granted", {arb_busy, mmu_read}, 2'b11);
    end
    hang = 0;
    late_done = 1;
    quiesce();
    chk("wd_sticky", arb_timeout, 1'b1);
    do_reset();
    chk("wd_cleared", arb_timeout, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish before 500000");
    $fatal(1);
  end
endmodule

// File: doc/l1mmu_arbiter.md
Name: l1mmu_arbiter

Overview:
- Shares the single l1mmu refill/writeback port between the L1 I-cache and the L1 D-cache.
- Replaces the combinational "I-cache always wins" mux in top.
- Latches one requester's transaction and holds it stable to l1mmu until mmu_done. Arbitrates round-robin on simultaneous requests and inserts one release cycle between transactions.
- Flags transactions that hang, via a watchdog.

Parameters:
- ADDR_W, 32, request address width.
- LINE_W, 256, cache line width in bits.
- TIMEOUT, 1024, cycles a granted transaction may wait for mmu_done before arb_timeout sets. 0 disables the watchdog.

Ports:
- sys_clk  in  1  system clock; everything is posedge.
- rst_n  in  1  asynchronous active-low reset.
- ic_read  in  1  I-cache line read request; level, held until ic_done.
- ic_addr  in  ADDR_W  I-cache line address.
- ic_done  out  1  one-cycle completion pulse to the I-cache.
- ic_read_data  out  LINE_W  line data to the I-cache.
- dc_read  in  1  D-cache line read request; level.
- dc_write  in  1  D-cache line writeback request; level. Never asserted together with dc_read.
- dc_addr  in  ADDR_W  D-cache line address.
- dc_write_data  in  LINE_W  writeback line.
- dc_done  out  1  one-cycle completion pulse to the D-cache.
- dc_read_data  out  LINE_W  line data to the D-cache.
- mmu_read  out  1  read request to l1mmu.
- mmu_write  out  1  write request to l1mmu.
- mmu_addr  out  ADDR_W  address to l1mmu.
- mmu_write_data  out  LINE_W  write line to l1mmu.
- mmu_done  in  1  l1mmu completion pulse.
- mmu_read_data  in  LINE_W  l1mmu read line.
- arb_busy  out  1  a transaction is outstanding; state is GRANT_I or GRANT_D.
- arb_timeout  out  1  sticky watchdog flag; cleared only by reset.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- Reset, asynchronous, on rst_n low:
  - state = IDLE, last_owner = D, so the I-cache wins the first tie.
  - Watchdog counter = 0, arb_timeout = 0.
  - All latched address/data/type registers = 0.
  - mmu_read, mmu_write, ic_done, dc_done, arb_busy = 0.
- IDLE:
  - Requester I = ic_read. Requester D = dc_read | dc_write.
  - Only one requester → grant it.
  - Both requesting → grant the one that is not last_owner.
  - On grant, register the address, the write data, and the type (read/write) from the winner. Set last_owner and go to GRANT_x.
  - Nothing requesting → stay in IDLE.
- GRANT_x:
  - mmu_read/mmu_write/mmu_addr/mmu_write_data are driven from the latched registers only, so the l1mmu inputs are stable for the whole transaction.
  - Latency: a request sampled in IDLE at edge N appears on mmu_* in cycle N+1.
  - ic_done = (state==GRANT_I) & mmu_done. dc_done = (state==GRANT_D) & mmu_done. Both are combinational, in the same cycle as mmu_done.
  - On mmu_done, go to RELEASE.
- RELEASE:
  - mmu_read = mmu_write = 0 for exactly one cycle, so l1mmu returns to idle and the requester can drop its level.
  - Then go to IDLE.
  - A requester still asserting in RELEASE is arbitrated normally in the next IDLE cycle.
- ic_read_data and dc_read_data are both driven by mmu_read_data, broadcast at all times. Consumers qualify with their own done.
- Requester drop mid-grant (e.g. I-cache flushed by a jump):
  - The transaction still runs to mmu_done.
  - The done pulse is still issued, and the requester ignores it.
  - The arbiter never aborts a transaction to l1mmu.
- mmu_done outside GRANT_x is ignored. No done pulse is issued and there is no state change.
- Watchdog:
  - The counter increments in GRANT_x and clears on entry to GRANT_x.
  - When the counter reaches TIMEOUT, arb_timeout sets. The state machine is not affected.
  - The counter saturates and does not wrap.
- Fairness: after any D transaction, a simultaneous I+D request goes to I, and vice versa. Neither side waits more than one foreign transaction.
- arb_busy = 1 in GRANT_I and GRANT_D only.

Decomposition:
- Shared package (mmu_pkg): state encoding constants ARB_IDLE/ARB_GRANT_I/ARB_GRANT_D/ARB_RELEASE, owner encoding OWNER_I/OWNER_D, LINE_W and ADDR_W defaults.
- No sub-module: a single FSM plus latch registers plus the watchdog counter.
- top instantiates l1mmu_arbiter in place of the serve_ic mux.

Test Plan:
- Reset: hold rst_n=0 with ic_read=1 → all outputs 0. Release reset → mmu_read=1 with mmu_addr=ic_addr one cycle after the first sampling edge.
- Single I-cache read: ic_addr=0x00400020, l1mmu model returns done after 5 cycles with data 0xA5..A5 → exactly one ic_done pulse, ic_read_data=0xA5..A5, dc_done=0 throughout, then one RELEASE cycle with mmu_read=0.
- Tie: ic_read and dc_write (dc_addr=0x10010000) asserted in the same cycle after reset → I served first; D served after RELEASE with mmu_write=1 and mmu_write_data=dc_write_data. The next tie goes to I only if D was last.
- Stability: change dc_addr to 0xDEADBEE0 mid-GRANT_D (dc_addr=0x10010040) → mmu_addr stays 0x10010040 until mmu_done.
- Requester drop: deassert ic_read two cycles into GRANT_I → mmu_read held until mmu_done; ic_done still pulses; the FSM reaches IDLE via RELEASE.
- Watchdog: TIMEOUT=16, model never asserts done → arb_timeout=1 after 16 GRANT cycles, stays 1, and the FSM stays in GRANT. A late mmu_done completes normally with arb_timeout still 1. rst_n=0 clears it.
